ks_program_memory: RTL and testbench

Unified 32 x 16 program/data memory that answers the K&S data path's memory port: it receives the address, write data and write strobe, and returns read data. After reset it runs a boot-loader state machine that accepts the program as a byte stream over a valid/ready handshake and writes it from word 0 upward. During loading it holds the processor in reset, then releases it. It sits beside the data path and control unit at the top level.

---
 rtl/k_and_s_pkg.sv | 33 +++
 rtl/ks_sync_ram.sv | 34 +++
 rtl/ks_program_memory.sv | 114 +++++++++++
 tb/tb_ks_program_memory.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/k_and_s_pkg.sv
// Shared types and constants for the K&S processor: instruction decode
// and the boot-loading program memory.
package k_and_s_pkg;

  typedef enum logic [3:0] {
    I_NOP,
    I_LOAD,
    I_STORE,
    I_MOVE,
    I_ADD,
    I_SUB,
    I_AND,
    I_OR,
    I_BRANCH,
    I_BZERO,
    I_BNEG,
    I_BOV,
    I_BNZERO,
    I_BNNEG,
    I_BNOV,
    I_HALT
  } decoded_instruction_type;

  typedef enum logic [1:0] {
    LOAD_HI,
    LOAD_LO,
    RUN
  } mem_state_type;

  localparam int MEM_ADDR_W = 5;
  localparam int MEM_DATA_W = 16;

endpackage

// File: rtl/ks_sync_ram.sv
// Single-port synchronous RAM with read-before-write and a clearable
// registered read port.
module ks_sync_ram #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rd_clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // NOTE: the array gets no reset so it maps onto RAM primitives; only the
  // read register below is cleared.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Sampling mem[addr] on the same edge as the write returns the old word.
  always_ff @(posedge clk) begin
    if (rd_clr) begin
      rdata <= '0;
    end else begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/ks_program_memory.sv
// Program/data memory for the K&S data path with a byte-stream boot loader
// that fills the array from word 0 and holds the processor in reset until done.
module ks_program_memory
  import k_and_s_pkg::*;
#(
  parameter int ADDR_W    = MEM_ADDR_W,
  parameter int DATA_W    = MEM_DATA_W,
  parameter int SKIP_LOAD = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ram_addr,
  input  logic              ram_write_enable,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [7:0]        load_data,
  input  logic              load_last,
  output logic              load_done,
  output logic              cpu_rst_n,
  output logic [ADDR_W:0]   load_count
);

  localparam logic [ADDR_W-1:0] PTR_MAX    = '1;
  localparam logic [ADDR_W-1:0] PTR_ONE    = 1;
  localparam logic [ADDR_W:0]   CNT_ONE    = 1;
  localparam mem_state_type     RESET_STATE = (SKIP_LOAD != 0) ? RUN : LOAD_HI;

  mem_state_type     state_q;
  mem_state_type     next_state;
  logic [ADDR_W-1:0] load_ptr;
  logic [7:0]        hi_q;
  logic              accept;
  logic              run;

  logic              ram_we;
  logic              ram_rd_clr;
  logic [ADDR_W-1:0] ram_port_addr;
  logic [DATA_W-1:0] ram_wdata;

  assign accept = load_valid && load_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RESET_STATE;
    end else begin
      state_q <= next_state;
    end
  end

  // NOTE: every comb output gets a default first so no path infers a latch.
  always_comb begin
    next_state = state_q;
    unique case (state_q)
      LOAD_HI: if (accept) next_state = LOAD_LO;
      LOAD_LO: begin
        if (accept) begin
          next_state = (load_last || load_ptr == PTR_MAX) ? RUN : LOAD_HI;
        end
      end
      RUN:     next_state = RUN;
      default: next_state = LOAD_HI;
    endcase
  end

  always_comb begin
    run           = (state_q == RUN);
    load_ready    = !run;
    load_done     = run;
    cpu_rst_n     = run;
    ram_port_addr = run ? ram_addr : load_ptr;
    ram_wdata     = run ? wr_data : {hi_q, load_data};
    // Writes are suppressed while rst_n is low so a reset mid-word cannot
    // commit a half-assembled value.
    ram_we        = rst_n && (run ? ram_write_enable
                                  : (state_q == LOAD_LO && load_valid));
    ram_rd_clr    = !rst_n || !run;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      load_ptr   <= '0;
      load_count <= '0;
      hi_q       <= '0;
    end else begin
      if (state_q == LOAD_HI && accept) begin
        hi_q <= load_data;
      end
      if (state_q == LOAD_LO && accept) begin
        load_count <= load_count + CNT_ONE;
        // The last word lands at PTR_MAX and forces RUN, so the pointer stops there.
        if (load_ptr != PTR_MAX) begin
          load_ptr <= load_ptr + PTR_ONE;
        end
      end
    end
  end

  ks_sync_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .clk   (clk),
    .rd_clr(ram_rd_clr),
    .we    (ram_we),
    .addr  (ram_port_addr),
    .wdata (ram_wdata),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_ks_program_memory.sv
// Self-checking bench for ks_program_memory: loader scenarios, RUN access
// through a read scoreboard, mid-load reset and a SKIP_LOAD instance.
module tb_ks_program_memory;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  ram_addr;
  logic        ram_write_enable;
  logic [15:0] wr_data;
  logic [15:0] rd_data;
  logic        load_valid;
  logic        load_ready;
  logic [7:0]  load_data;
  logic        load_last;
  logic        load_done;
  logic        cpu_rst_n;
  logic [5:0]  load_count;

  logic [4:0]  s_ram_addr;
  logic        s_ram_write_enable;
  logic [15:0] s_wr_data;
  logic [15:0] s_rd_data;
  logic        s_load_ready;
  logic        s_load_done;
  logic        s_cpu_rst_n;
  logic [5:0]  s_load_count;

  int tests  = 0;
  int errors = 0;

  logic [15:0] model_mem [32];
  logic [15:0] exp_q [$];
  logic [4:0]  addr_q [$];
  logic        rd_req = 1'b0;

  always #5 clk = ~clk;

  ks_program_memory #(.ADDR_W(5), .DATA_W(16), .SKIP_LOAD(0)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ram_addr        (ram_addr),
    .ram_write_enable(ram_write_enable),
    .wr_data         (wr_data),
    .rd_data         (rd_data),
    .load_valid      (load_valid),
    .load_ready      (load_ready),
    .load_data       (load_data),
    .load_last       (load_last),
    .load_done       (load_done),
    .cpu_rst_n       (cpu_rst_n),
    .load_count      (load_count)
  );

  ks_program_memory #(.ADDR_W(5), .DATA_W(16), .SKIP_LOAD(1)) dut_skip (
    .clk             (clk),
    .rst_n           (rst_n),
    .ram_addr        (s_ram_addr),
    .ram_write_enable(s_ram_write_enable),
    .wr_data         (s_wr_data),
    .rd_data         (s_rd_data),
    .load_valid      (1'b1),
    .load_ready      (s_load_ready),
    .load_data       (8'h5A),
    .load_last       (1'b0),
    .load_done       (s_load_done),
    .cpu_rst_n       (s_cpu_rst_n),
    .load_count      (s_load_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock; samples 1 time unit after the edge and retires a pending read.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rd_req) begin
      rd_req = 1'b0;
      check($sformatf("read[%0d]", addr_q.pop_front()), rd_data, exp_q.pop_front());
    end
  endtask

  task automatic issue_read(input logic [4:0] a);
    ram_addr = a;
    addr_q.push_back(a);
    exp_q.push_back(model_mem[a]);
    rd_req = 1'b1;
  endtask

  task automatic read_check(input logic [4:0] a);
    issue_read(a);
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    load_valid = 1'b1;
    load_data  = b;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] bytes3 [6];
    bytes3 = '{8'h80, 8'h41, 8'hA0, 8'h12, 8'hFF, 8'h80};

    rst_n = 1'b0;
    ram_addr = '0; ram_write_enable = 1'b0; wr_data = '0;
    load_valid = 1'b0; load_data = '0; load_last = 1'b0;
    s_ram_addr = '0; s_ram_write_enable = 1'b0; s_wr_data = '0;
    tick();
    tick();

    // Reset state, both instances
    check("rst_ready", load_ready, 1);
    check("rst_done", load_done, 0);
    check("rst_cpu_rst_n", cpu_rst_n, 0);
    check("rst_count", load_count, 0);
    check("rst_rd_data", rd_data, 0);
    check("skip_done", s_load_done, 1);
    check("skip_cpu_rst_n", s_cpu_rst_n, 1);
    check("skip_ready", s_load_ready, 0);
    rst_n = 1'b1;

    // SKIP_LOAD instance: processor write in the first cycle, then read back
    s_ram_addr = 5'd3; s_wr_data = 16'hA5A5; s_ram_write_enable = 1'b1;
    tick();
    s_ram_write_enable = 1'b0;
    tick();
    check("skip_read", s_rd_data, 16'hA5A5);

    // Three words, load_valid held high, last on byte 6
    for (int i = 0; i < 6; i++) begin
      send_byte(bytes3[i], i == 5);
      if (i == 4) check("t1_rd_held0", rd_data, 0);
      if (i < 5) check($sformatf("t1_done_early%0d", i), load_done, 0);
    end
    check("t1_count", load_count, 3);
    check("t1_done", load_done, 1);
    check("t1_cpu_rst_n", cpu_rst_n, 1);
    check("t1_ready", load_ready, 0);
    model_mem[0] = 16'h8041; model_mem[1] = 16'hA012; model_mem[2] = 16'hFF80;
    for (int a = 0; a < 3; a++) read_check(5'(a));

    // Full load of 32 words with no load_last
    do_reset();
    check("t2_count_rst", load_count, 0);
    for (int k = 0; k < 32; k++) begin
      logic [15:0] w;
      w = 16'h0100 + 16'(k);
      send_byte(w[15:8], 1'b0);
      send_byte(w[7:0], 1'b0);
      model_mem[k] = w;
      if (k == 30) check("t2_not_done", load_done, 0);
    end
    check("t2_done", load_done, 1);
    check("t2_count", load_count, 32);
    send_byte(8'h55, 1'b0);
    send_byte(8'hAA, 1'b1);
    check("t2_count_after", load_count, 32);
    read_check(5'd31);
    read_check(5'd0);

    // Gapped handshake with load_last on a high byte; processor writes ignored
    do_reset();
    ram_addr = 5'd20; wr_data = 16'hDEAD; ram_write_enable = 1'b1;
    begin
      logic [7:0] gb [4];
      logic       gl [4];
      gb = '{8'h12, 8'h34, 8'h56, 8'h78};
      gl = '{1'b1, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 4; i++) begin
        send_byte(gb[i], gl[i]);
        load_data = 8'hEE;
        load_last = 1'b1;
        if (i < 3) begin
          tick();
          check($sformatf("t3_not_done%0d", i), load_done, 0);
        end
        load_last = 1'b0;
      end
    end
    ram_write_enable = 1'b0;
    check("t3_done", load_done, 1);
    check("t3_count", load_count, 2);
    model_mem[0] = 16'h1234; model_mem[1] = 16'h5678;
    read_check(5'd0);
    read_check(5'd1);
    read_check(5'd20);
    read_check(5'd2);

    // RUN write and read of the same address on one edge
    ram_write_enable = 1'b1; wr_data = 16'h1234;
    issue_read(5'd7);
    tick();
    ram_write_enable = 1'b0;
    model_mem[7] = 16'h1234;
    read_check(5'd7);

    // Reset after three bytes, then reload word 0
    do_reset();
    send_byte(8'hCA, 1'b0);
    send_byte(8'hFE, 1'b0);
    send_byte(8'h11, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t5_ready", load_ready, 1);
    check("t5_count", load_count, 0);
    check("t5_cpu_rst_n", cpu_rst_n, 0);
    check("t5_done", load_done, 0);
    send_byte(8'hBE, 1'b0);
    send_byte(8'hEF, 1'b1);
    check("t5_count_after", load_count, 1);
    check("t5_done_after", load_done, 1);
    model_mem[0] = 16'hBEEF;
    read_check(5'd0);
    read_check(5'd1);
    read_check(5'd7);

    check("sb_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
